// File: rtl/uc_mem_responder_pkg.sv
// Shared types and address helpers for the uncached memory responder.
package uc_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_BEAT = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_WR_RESP = 2'd3
  } state_e;

  // A beat is serviceable only for non-atomic requests whose byte address
  // falls inside the storage window; every beat of a burst wraps inside it.
  function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] base,
                                   input logic [63:0] span, input logic atomic);
    return !atomic && (addr >= base) && ((addr - base) < span);
  endfunction

  // Word index of a beat: word-aligned address plus beat number, wrapped to
  // the storage depth.
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w, input logic [31:0] beat);
    logic [31:0] word;
    word = 32'(addr >> off_w);
    return (word + beat) & ((32'd1 << idx_w) - 32'd1);
  endfunction

endpackage

// File: rtl/uc_mem_responder_if.sv
// Uncached read/write request, data and response channels between the dCache
// side (master) and the memory-side responder (slave).
interface uc_mem_responder_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
);
  logic                  rd_req_valid_i;
  logic                  rd_req_ready_o;
  logic [ADDR_W-1:0]     rd_req_addr_i;
  logic [LEN_W-1:0]      rd_req_len_i;
  logic [ID_W-1:0]       rd_req_id_i;
  logic                  rd_req_atomic_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_W-1:0]     rd_data_o;
  logic [ID_W-1:0]       rd_id_o;
  logic                  rd_error_o;
  logic                  rd_last_o;
  logic                  wr_req_valid_i;
  logic                  wr_req_ready_o;
  logic [ADDR_W-1:0]     wr_req_addr_i;
  logic [LEN_W-1:0]      wr_req_len_i;
  logic [ID_W-1:0]       wr_req_id_i;
  logic                  wr_req_atomic_i;
  logic                  wr_data_valid_i;
  logic                  wr_data_ready_o;
  logic [DATA_W-1:0]     wr_data_i;
  logic [DATA_W/8-1:0]   wr_be_i;
  logic                  wr_last_i;
  logic                  wr_resp_valid_o;
  logic                  wr_resp_ready_i;
  logic [ID_W-1:0]       wr_resp_id_o;
  logic                  wr_resp_error_o;
  logic                  wr_resp_is_atomic_o;

  modport slave (
    input  rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i, rd_req_atomic_i,
    output rd_req_ready_o,
    output rd_valid_o, rd_data_o, rd_id_o, rd_error_o, rd_last_o,
    input  rd_ready_i,
    input  wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_id_i, wr_req_atomic_i,
    output wr_req_ready_o,
    input  wr_data_valid_i, wr_data_i, wr_be_i, wr_last_i,
    output wr_data_ready_o,
    output wr_resp_valid_o, wr_resp_id_o, wr_resp_error_o, wr_resp_is_atomic_o,
    input  wr_resp_ready_i
  );

  modport master (
    output rd_req_valid_i, rd_req_addr_i, rd_req_len_i, rd_req_id_i, rd_req_atomic_i,
    input  rd_req_ready_o,
    input  rd_valid_o, rd_data_o, rd_id_o, rd_error_o, rd_last_o,
    output rd_ready_i,
    output wr_req_valid_i, wr_req_addr_i, wr_req_len_i, wr_req_id_i, wr_req_atomic_i,
    input  wr_req_ready_o,
    output wr_data_valid_i, wr_data_i, wr_be_i, wr_last_i,
    input  wr_data_ready_o,
    input  wr_resp_valid_o, wr_resp_id_o, wr_resp_error_o, wr_resp_is_atomic_o,
    output wr_resp_ready_i
  );
endinterface

// File: rtl/uc_mem_responder_ram.sv
// Word storage: byte-enabled synchronous write, asynchronous read, synchronous clear.
module uc_mem_responder_ram #(
  parameter int DATA_W    = 512,
  parameter int NUM_WORDS = 16,
  localparam int IDX_W    = $clog2(NUM_WORDS),
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [BE_W-1:0]   wbe,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_WORDS];

  // Clear wins over a write landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (clr) begin
      for (int w = 0; w < NUM_WORDS; w++) mem[w] <= '0;
    end else if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uc_mem_responder.sv
// Memory-side responder for uncached read/write traffic: one transaction at a
// time, terminated into a small word-addressed register file.
module uc_mem_responder
  import uc_mem_responder_pkg::*;
#(
  parameter int ADDR_W                = 40,
  parameter int DATA_W                = 512,
  parameter int ID_W                  = 4,
  parameter int LEN_W                 = 8,
  parameter int NUM_WORDS             = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h4000_0000
) (
  input logic               clk_i,
  input logic               rst_i,
  uc_mem_responder_if.slave bus
);
  localparam int          BE_W  = DATA_W / 8;
  localparam int          OFF_W = $clog2(BE_W);
  localparam int          IDX_W = $clog2(NUM_WORDS);
  localparam logic [63:0] SPAN  = 64'(NUM_WORDS * BE_W);

  state_e             state, state_nx;
  logic               rr_rd;
  logic               rd_req_rdy, wr_req_rdy, wr_data_rdy;
  logic               grant_rd, grant_wr, rd_hs, wd_hs, wr_resp_hs;
  logic [ADDR_W-1:0]  addr_q, lk_addr;
  logic [LEN_W-1:0]   len_q, beat_q, lk_beat;
  logic [ID_W-1:0]    id_q;
  logic               atomic_q, lk_atomic, err_q;
  logic               lk_ok, wr_ok, ram_we;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic [DATA_W-1:0]  ram_rdata;
  logic               rd_valid_q, rd_err_q, rd_last_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic [ID_W-1:0]    rd_id_q, wr_resp_id_q;
  logic               wr_resp_valid_q, wr_resp_err_q, wr_resp_atomic_q;

  // State register and round-robin pointer; pointer toggles on every grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      rr_rd <= 1'b1;
    end else begin
      state <= state_nx;
      if (grant_rd || grant_wr) rr_rd <= !rr_rd;
    end
  end

  // Next state, request arbitration and channel readies.
  always_comb begin
    state_nx    = state;
    rd_req_rdy  = 1'b0;
    wr_req_rdy  = 1'b0;
    wr_data_rdy = 1'b0;
    rd_hs       = 1'b0;
    wd_hs       = 1'b0;
    wr_resp_hs  = 1'b0;
    case (state)
      ST_IDLE: begin
        rd_req_rdy = !rst_i && (rr_rd || !bus.wr_req_valid_i);
        wr_req_rdy = !rst_i && (!rr_rd || !bus.rd_req_valid_i);
        if (rd_req_rdy && bus.rd_req_valid_i)      state_nx = ST_RD_BEAT;
        else if (wr_req_rdy && bus.wr_req_valid_i) state_nx = ST_WR_DATA;
      end
      ST_RD_BEAT: begin
        rd_hs = rd_valid_q && bus.rd_ready_i;
        if (rd_hs && rd_last_q) state_nx = ST_IDLE;
      end
      ST_WR_DATA: begin
        wr_data_rdy = !rst_i;
        wd_hs       = wr_data_rdy && bus.wr_data_valid_i;
        if (wd_hs && bus.wr_last_i) state_nx = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        wr_resp_hs = wr_resp_valid_q && bus.wr_resp_ready_i;
        if (wr_resp_hs) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign grant_rd = rd_req_rdy && bus.rd_req_valid_i;
  assign grant_wr = wr_req_rdy && bus.wr_req_valid_i;

  // Read lookup: first beat comes straight from the request, later beats from
  // the latched request and the next beat number.
  always_comb begin
    lk_addr   = addr_q;
    lk_atomic = atomic_q;
    lk_beat   = beat_q + 1'b1;
    if (state == ST_IDLE) begin
      lk_addr   = bus.rd_req_addr_i;
      lk_atomic = bus.rd_req_atomic_i;
      lk_beat   = '0;
    end
  end

  assign lk_ok  = addr_ok(64'(lk_addr), 64'(BASE_ADDR), SPAN, lk_atomic);
  assign rd_idx = IDX_W'(word_index(64'(lk_addr), OFF_W, IDX_W, 32'(lk_beat)));
  assign wr_ok  = addr_ok(64'(addr_q), 64'(BASE_ADDR), SPAN, atomic_q);
  assign wr_idx = IDX_W'(word_index(64'(addr_q), OFF_W, IDX_W, 32'(beat_q)));
  assign ram_we = wd_hs && wr_ok;

  uc_mem_responder_ram #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_ram (
    .clk_i (clk_i),
    .clr   (rst_i),
    .we    (ram_we),
    .waddr (wr_idx),
    .wbe   (bus.wr_be_i),
    .wdata (bus.wr_data_i),
    .raddr (rd_idx),
    .rdata (ram_rdata)
  );

  // Request capture, read beat sequencing, write error tracking and responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q           <= '0;
      len_q            <= '0;
      id_q             <= '0;
      atomic_q         <= 1'b0;
      beat_q           <= '0;
      err_q            <= 1'b0;
      rd_valid_q       <= 1'b0;
      rd_data_q        <= '0;
      rd_id_q          <= '0;
      rd_err_q         <= 1'b0;
      rd_last_q        <= 1'b0;
      wr_resp_valid_q  <= 1'b0;
      wr_resp_id_q     <= '0;
      wr_resp_err_q    <= 1'b0;
      wr_resp_atomic_q <= 1'b0;
    end else begin
      if (grant_rd || grant_wr) begin
        addr_q   <= grant_rd ? bus.rd_req_addr_i   : bus.wr_req_addr_i;
        len_q    <= grant_rd ? bus.rd_req_len_i    : bus.wr_req_len_i;
        id_q     <= grant_rd ? bus.rd_req_id_i     : bus.wr_req_id_i;
        atomic_q <= grant_rd ? bus.rd_req_atomic_i : bus.wr_req_atomic_i;
        beat_q   <= '0;
        err_q    <= 1'b0;
      end
      if (grant_rd) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= lk_ok ? ram_rdata : '0;
        rd_id_q    <= bus.rd_req_id_i;
        rd_err_q   <= !lk_ok;
        rd_last_q  <= (bus.rd_req_len_i == '0);
      end
      if (rd_hs) begin
        if (rd_last_q) begin
          rd_valid_q <= 1'b0;
        end else begin
          beat_q    <= lk_beat;
          rd_data_q <= lk_ok ? ram_rdata : '0;
          rd_err_q  <= !lk_ok;
          rd_last_q <= (lk_beat == len_q);
        end
      end
      if (wd_hs) begin
        if (bus.wr_last_i) begin
          wr_resp_valid_q  <= 1'b1;
          wr_resp_id_q     <= id_q;
          wr_resp_err_q    <= err_q || !wr_ok || (beat_q != len_q);
          wr_resp_atomic_q <= atomic_q;
        end else begin
          beat_q <= beat_q + 1'b1;
          // An out-of-window beat or a burst running past len is sticky.
          if (!wr_ok || (beat_q == len_q)) err_q <= 1'b1;
        end
      end
      if (wr_resp_hs) wr_resp_valid_q <= 1'b0;
    end
  end

  assign bus.rd_req_ready_o      = rd_req_rdy;
  assign bus.wr_req_ready_o      = wr_req_rdy;
  assign bus.wr_data_ready_o     = wr_data_rdy;
  assign bus.rd_valid_o          = rd_valid_q;
  assign bus.rd_data_o           = rd_data_q;
  assign bus.rd_id_o             = rd_id_q;
  assign bus.rd_error_o          = rd_err_q;
  assign bus.rd_last_o           = rd_last_q;
  assign bus.wr_resp_valid_o     = wr_resp_valid_q;
  assign bus.wr_resp_id_o        = wr_resp_id_q;
  assign bus.wr_resp_error_o     = wr_resp_err_q;
  assign bus.wr_resp_is_atomic_o = wr_resp_atomic_q;
endmodule

// File: tb/tb_uc_mem_responder.sv
// Directed bench for uc_mem_responder: reset state, single/burst reads and
// writes, byte enables, wrap, window/atomic errors, arbitration, back-pressure
// and mid-transaction reset.
module tb_uc_mem_responder;
  localparam logic [39:0]  BASE     = 40'h00_4000_0000;
  localparam logic [39:0]  BASE_M64 = 40'h00_3FFF_FFC0;
  localparam logic [39:0]  W1       = 40'h00_4000_0040;
  localparam logic [39:0]  W2       = 40'h00_4000_0080;
  localparam logic [39:0]  W15      = 40'h00_4000_03C0;
  localparam logic [511:0] D_A5     = {64{8'hA5}};
  localparam logic [511:0] D_FF     = {64{8'hFF}};
  localparam logic [511:0] D_15     = {64{8'h15}};
  localparam logic [511:0] D_66     = {64{8'h66}};
  localparam logic [511:0] D_3C     = {64{8'h3C}};
  localparam logic [511:0] D_5A     = {64{8'h5A}};
  localparam logic [511:0] D_77     = {64{8'h77}};
  localparam logic [511:0] D_W2     = {{60{8'hFF}}, 32'h0};
  localparam logic [63:0]  BE_ALL   = {64{1'b1}};

  logic tb_clk = 1'b0;
  logic tb_rst = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;

  always #5 tb_clk = ~tb_clk;

  uc_mem_responder_if bus ();

  uc_mem_responder dut (
    .clk_i (tb_clk),
    .rst_i (tb_rst),
    .bus   (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-beat write; the data beat is offered together with the request so
  // it must stall until the request is taken.
  task automatic do_wr(input string tag, input logic [39:0] a, input logic [7:0] l,
                       input logic [3:0] id, input logic at, input logic [511:0] d,
                       input logic [63:0] be, input logic exp_err);
    int k;
    @(posedge tb_clk); #1;
    bus.wr_req_valid_i  = 1'b1;
    bus.wr_req_addr_i   = a;
    bus.wr_req_len_i    = l;
    bus.wr_req_id_i     = id;
    bus.wr_req_atomic_i = at;
    bus.wr_data_valid_i = 1'b1;
    bus.wr_data_i       = d;
    bus.wr_be_i         = be;
    bus.wr_last_i       = 1'b1;
    bus.wr_resp_ready_i = 1'b0;
    @(negedge tb_clk);
    chk1({tag, "_data_stall"}, bus.wr_data_ready_o, 1'b0);
    k = 0;
    while (bus.wr_req_ready_o !== 1'b1 && k < 20) begin @(negedge tb_clk); k++; end
    chk1({tag, "_req_grant"}, k < 20, 1'b1);
    @(posedge tb_clk); #1;
    bus.wr_req_valid_i = 1'b0;
    @(negedge tb_clk);
    k = 0;
    while (bus.wr_data_ready_o !== 1'b1 && k < 20) begin @(negedge tb_clk); k++; end
    chk1({tag, "_data_rdy"}, k < 20, 1'b1);
    @(posedge tb_clk); #1;
    bus.wr_data_valid_i = 1'b0;
    bus.wr_last_i       = 1'b0;
    @(negedge tb_clk);
    chk1({tag, "_resp_valid"}, bus.wr_resp_valid_o, 1'b1);
    @(negedge tb_clk);
    chk1({tag, "_resp_held"}, bus.wr_resp_valid_o, 1'b1);
    chki({tag, "_resp_id"}, bus.wr_resp_id_o, id);
    chk1({tag, "_resp_err"}, bus.wr_resp_error_o, exp_err);
    chk1({tag, "_resp_atomic"}, bus.wr_resp_is_atomic_o, at);
    bus.wr_resp_ready_i = 1'b1;
    @(posedge tb_clk); #1;
    bus.wr_resp_ready_i = 1'b0;
    @(negedge tb_clk);
    chk1({tag, "_resp_done"}, bus.wr_resp_valid_o, 1'b0);
  endtask

  // Read of one or two beats with rd_ready_i held high.
  task automatic do_rd(input string tag, input logic [39:0] a, input logic [7:0] l,
                       input logic [3:0] id, input logic at, input logic exp_err,
                       input logic [511:0] d0, input logic [511:0] d1);
    int k;
    logic [511:0] exp_d;
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i  = 1'b1;
    bus.rd_req_addr_i   = a;
    bus.rd_req_len_i    = l;
    bus.rd_req_id_i     = id;
    bus.rd_req_atomic_i = at;
    bus.rd_ready_i      = 1'b1;
    @(negedge tb_clk);
    k = 0;
    while (bus.rd_req_ready_o !== 1'b1 && k < 20) begin @(negedge tb_clk); k++; end
    chk1({tag, "_req_grant"}, k < 20, 1'b1);
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i = 1'b0;
    for (int b = 0; b <= int'(l); b++) begin
      exp_d = (b == 0) ? d0 : d1;
      @(negedge tb_clk);
      chk1($sformatf("%s_valid%0d", tag, b), bus.rd_valid_o, 1'b1);
      chkd($sformatf("%s_data%0d", tag, b), bus.rd_data_o, exp_d);
      chki($sformatf("%s_id%0d", tag, b), bus.rd_id_o, id);
      chk1($sformatf("%s_err%0d", tag, b), bus.rd_error_o, exp_err);
      chk1($sformatf("%s_last%0d", tag, b), bus.rd_last_o, b == int'(l));
      @(posedge tb_clk); #1;
    end
    @(negedge tb_clk);
    chk1({tag, "_end"}, bus.rd_valid_o, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rd_req_valid_i  = 1'b0;
    bus.rd_req_addr_i   = '0;
    bus.rd_req_len_i    = '0;
    bus.rd_req_id_i     = '0;
    bus.rd_req_atomic_i = 1'b0;
    bus.rd_ready_i      = 1'b0;
    bus.wr_req_valid_i  = 1'b0;
    bus.wr_req_addr_i   = '0;
    bus.wr_req_len_i    = '0;
    bus.wr_req_id_i     = '0;
    bus.wr_req_atomic_i = 1'b0;
    bus.wr_data_valid_i = 1'b0;
    bus.wr_data_i       = '0;
    bus.wr_be_i         = '0;
    bus.wr_last_i       = 1'b0;
    bus.wr_resp_ready_i = 1'b0;
    tb_rst              = 1'b1;

    // Reset state
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk1("rst_rd_req_ready", bus.rd_req_ready_o, 1'b0);
    chk1("rst_wr_req_ready", bus.wr_req_ready_o, 1'b0);
    chk1("rst_wr_data_ready", bus.wr_data_ready_o, 1'b0);
    chk1("rst_rd_valid", bus.rd_valid_o, 1'b0);
    chk1("rst_wr_resp_valid", bus.wr_resp_valid_o, 1'b0);
    chkd("rst_rd_data", bus.rd_data_o, '0);
    chki("rst_wr_resp_id", bus.wr_resp_id_o, 4'h0);
    @(posedge tb_clk); #1;
    tb_rst = 1'b0;

    // Basic single-beat write then read back
    do_wr("wr_base", BASE, 8'd0, 4'd3, 1'b0, D_A5, BE_ALL, 1'b0);
    do_rd("rd_base", BASE, 8'd0, 4'd5, 1'b0, 1'b0, D_A5, '0);

    // Partial byte enables over earlier data
    do_wr("wr_w2_ff", W2, 8'd0, 4'd1, 1'b0, D_FF, BE_ALL, 1'b0);
    do_wr("wr_w2_be", W2, 8'd0, 4'd2, 1'b0, '0, 64'h0F, 1'b0);
    do_rd("rd_w2", W2, 8'd0, 4'd4, 1'b0, 1'b0, D_W2, '0);

    // Two-beat read wrapping from word 15 to word 0
    do_wr("wr_w15", W15, 8'd0, 4'd7, 1'b0, D_15, BE_ALL, 1'b0);
    do_rd("rd_wrap", W15, 8'd1, 4'd8, 1'b0, 1'b0, D_15, D_A5);

    // Out-of-window and atomic requests
    do_rd("rd_below", BASE_M64, 8'd0, 4'd7, 1'b0, 1'b1, '0, '0);
    do_rd("rd_atomic", BASE, 8'd0, 4'd9, 1'b1, 1'b1, '0, '0);
    do_wr("wr_below", BASE_M64, 8'd0, 4'd10, 1'b0, {64{8'h11}}, BE_ALL, 1'b1);
    do_wr("wr_atomic", BASE, 8'd0, 4'd2, 1'b1, {64{8'h22}}, BE_ALL, 1'b1);
    do_rd("rd_base_kept", BASE, 8'd0, 4'd1, 1'b0, 1'b0, D_A5, '0);
    do_rd("rd_w15_kept", W15, 8'd0, 4'd2, 1'b0, 1'b0, D_15, '0);

    // Burst ends early on wr_last_i: count mismatch errs, the beat still lands
    do_wr("wr_short", W1, 8'd1, 4'd11, 1'b0, D_66, BE_ALL, 1'b1);
    do_rd("rd_w1", W1, 8'd0, 4'd12, 1'b0, 1'b0, D_66, '0);

    // Back-pressure: beat held stable for 5 cycles with rd_ready_i low
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i  = 1'b1;
    bus.rd_req_addr_i   = BASE;
    bus.rd_req_len_i    = 8'd0;
    bus.rd_req_id_i     = 4'd6;
    bus.rd_req_atomic_i = 1'b0;
    bus.rd_ready_i      = 1'b0;
    @(negedge tb_clk);
    chk1("hold_req_ready", bus.rd_req_ready_o, 1'b1);
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge tb_clk);
      chk1($sformatf("hold_valid%0d", i), bus.rd_valid_o, 1'b1);
      chkd($sformatf("hold_data%0d", i), bus.rd_data_o, D_A5);
      chki($sformatf("hold_id%0d", i), bus.rd_id_o, 4'd6);
      chk1($sformatf("hold_last%0d", i), bus.rd_last_o, 1'b1);
      @(posedge tb_clk); #1;
    end
    bus.rd_ready_i = 1'b1;
    @(negedge tb_clk);
    chkd("hold_release_data", bus.rd_data_o, D_A5);
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk1("hold_done", bus.rd_valid_o, 1'b0);

    // Arbitration from a fresh reset: read, write, read, write
    @(posedge tb_clk); #1;
    tb_rst = 1'b1;
    @(posedge tb_clk); #1;
    tb_rst = 1'b0;
    bus.rd_req_valid_i  = 1'b1;
    bus.rd_req_addr_i   = BASE;
    bus.rd_req_len_i    = 8'd0;
    bus.rd_req_id_i     = 4'd1;
    bus.rd_req_atomic_i = 1'b0;
    bus.rd_ready_i      = 1'b1;
    bus.wr_req_valid_i  = 1'b1;
    bus.wr_req_addr_i   = BASE;
    bus.wr_req_len_i    = 8'd0;
    bus.wr_req_id_i     = 4'd2;
    bus.wr_req_atomic_i = 1'b0;
    bus.wr_resp_ready_i = 1'b1;
    @(negedge tb_clk);
    chk1("arb1_rd_ready", bus.rd_req_ready_o, 1'b1);
    chk1("arb1_wr_ready", bus.wr_req_ready_o, 1'b0);
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i = 1'b0;
    @(negedge tb_clk);
    chk1("arb1_rd_valid", bus.rd_valid_o, 1'b1);
    chkd("arb1_rd_data_cleared", bus.rd_data_o, '0);
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i = 1'b1;
    bus.rd_req_id_i    = 4'd5;
    @(negedge tb_clk);
    chk1("arb2_wr_ready", bus.wr_req_ready_o, 1'b1);
    chk1("arb2_rd_ready", bus.rd_req_ready_o, 1'b0);
    @(posedge tb_clk); #1;
    bus.wr_req_valid_i  = 1'b0;
    bus.wr_data_valid_i = 1'b1;
    bus.wr_data_i       = D_3C;
    bus.wr_be_i         = BE_ALL;
    bus.wr_last_i       = 1'b1;
    @(negedge tb_clk);
    chk1("arb2_data_ready", bus.wr_data_ready_o, 1'b1);
    @(posedge tb_clk); #1;
    bus.wr_data_valid_i = 1'b0;
    bus.wr_req_valid_i  = 1'b1;
    bus.wr_req_id_i     = 4'd6;
    @(negedge tb_clk);
    chk1("arb2_resp_valid", bus.wr_resp_valid_o, 1'b1);
    chki("arb2_resp_id", bus.wr_resp_id_o, 4'd2);
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk1("arb3_rd_ready", bus.rd_req_ready_o, 1'b1);
    chk1("arb3_wr_ready", bus.wr_req_ready_o, 1'b0);
    @(posedge tb_clk); #1;
    bus.rd_req_valid_i = 1'b0;
    @(negedge tb_clk);
    chkd("arb3_rd_data", bus.rd_data_o, D_3C);
    chki("arb3_rd_id", bus.rd_id_o, 4'd5);
    @(posedge tb_clk); #1;
    @(negedge tb_clk);
    chk1("arb4_wr_ready", bus.wr_req_ready_o, 1'b1);
    chk1("arb4_rd_ready", bus.rd_req_ready_o, 1'b0);
    @(posedge tb_clk); #1;
    bus.wr_req_valid_i  = 1'b0;
    bus.wr_data_valid_i = 1'b1;
    bus.wr_data_i       = D_5A;
    bus.wr_last_i       = 1'b1;
    @(negedge tb_clk);
    chk1("arb4_data_ready", bus.wr_data_ready_o, 1'b1);
    @(posedge tb_clk); #1;
    bus.wr_data_valid_i = 1'b0;
    bus.wr_last_i       = 1'b0;
    @(negedge tb_clk);
    chk1("arb4_resp_valid", bus.wr_resp_valid_o, 1'b1);
    chki("arb4_resp_id", bus.wr_resp_id_o, 4'd6);
    @(posedge tb_clk); #1;
    bus.wr_resp_ready_i = 1'b0;

    // Reset while in WR_DATA after one beat has landed
    @(posedge tb_clk); #1;
    bus.wr_req_valid_i  = 1'b1;
    bus.wr_req_addr_i   = BASE;
    bus.wr_req_len_i    = 8'd1;
    bus.wr_req_id_i     = 4'd4;
    bus.wr_req_atomic_i = 1'b0;
    bus.wr_data_valid_i = 1'b1;
    bus.wr_data_i       = D_77;
    bus.wr_be_i         = BE_ALL;
    bus.wr_last_i       = 1'b0;
    @(negedge tb_clk);
    chk1("mrst_req_ready", bus.wr_req_ready_o, 1'b1);
    @(posedge tb_clk); #1;
    bus.wr_req_valid_i = 1'b0;
    @(negedge tb_clk);
    chk1("mrst_data_ready", bus.wr_data_ready_o, 1'b1);
    @(posedge tb_clk); #1;
    bus.wr_data_valid_i = 1'b0;
    tb_rst = 1'b1;
    @(negedge tb_clk);
    chk1("mrst_in_rst_data_ready", bus.wr_data_ready_o, 1'b0);
    @(posedge tb_clk); #1;
    tb_rst = 1'b0;
    @(negedge tb_clk);
    chk1("mrst_rd_valid", bus.rd_valid_o, 1'b0);
    chk1("mrst_resp_valid", bus.wr_resp_valid_o, 1'b0);
    chk1("mrst_data_ready", bus.wr_data_ready_o, 1'b0);
    chk1("mrst_idle_rd_ready", bus.rd_req_ready_o, 1'b1);
    chk1("mrst_idle_wr_ready", bus.wr_req_ready_o, 1'b1);
    do_rd("mrst_rd_cleared", BASE, 8'd0, 4'd3, 1'b0, 1'b0, '0, '0);
    chk1("mrst_no_resp", bus.wr_resp_valid_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
